// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : default 1024x768@60 raster constants for the VGA timing block
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int VGA_H_VISIBLE      = 1024;
  localparam int VGA_H_FRONT        = 24;
  localparam int VGA_H_SYNC         = 136;
  localparam int VGA_H_BACK         = 160;
  localparam int VGA_H_TOTAL        = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE      = 768;
  localparam int VGA_V_FRONT        = 3;
  localparam int VGA_V_SYNC         = 6;
  localparam int VGA_V_BACK         = 29;
  localparam int VGA_V_TOTAL        = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_NARROW_VISIBLE = 960;

  localparam int H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC;
  localparam int V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : wrapping up-counter for one raster axis
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter #(
  parameter int               WIDTH    = 11,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Wrap is qualified by enable so the next axis only steps on a real rollover.
  assign wrap_o  = en_i && (count_q == TERMINAL);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i || wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_1024x768.sv
// ============================================================================
// vga_timing_1024x768 : free-running raster timing, sync/blank decode and
//                       sticky blank-entry interrupt
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_1024x768
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE      = VGA_H_VISIBLE,
  parameter int H_FRONT        = VGA_H_FRONT,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BACK         = VGA_H_BACK,
  parameter int V_VISIBLE      = VGA_V_VISIBLE,
  parameter int V_FRONT        = VGA_V_FRONT,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BACK         = VGA_V_BACK,
  parameter int NARROW_VISIBLE = VGA_NARROW_VISIBLE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cli,
  input  logic           enable_interrupt_on_hblank,
  input  logic           enable_interrupt_on_vblank,
  input  logic           narrow_960,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           retrace,
  output logic           blank,
  output logic           interrupt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam x_t HS_START_X = X_W'(H_VISIBLE + H_FRONT);
  localparam x_t HS_END_X   = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam x_t H_LAST_X   = X_W'(H_TOTAL - 1);
  localparam x_t H_VIS_X    = X_W'(H_VISIBLE);
  localparam x_t H_NAR_X    = X_W'(NARROW_VISIBLE);
  localparam y_t VS_START_Y = Y_W'(V_VISIBLE + V_FRONT);
  localparam y_t VS_END_Y   = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam y_t V_LAST_Y   = Y_W'(V_TOTAL - 1);
  localparam y_t V_VIS_Y    = Y_W'(V_VISIBLE);

  logic x_wrap;
  logic unused_y_wrap;

  vga_axis_counter #(
    .WIDTH    (X_W),
    .TERMINAL (H_LAST_X)
  ) u_x_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .en_i    (1'b1),
    .count_o (x),
    .wrap_o  (x_wrap)
  );

  vga_axis_counter #(
    .WIDTH    (Y_W),
    .TERMINAL (V_LAST_Y)
  ) u_y_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .en_i    (x_wrap),
    .count_o (y),
    .wrap_o  (unused_y_wrap)
  );

  // Narrow mode only moves the blank edge; sync positions stay on the 1024 grid.
  x_t   vis_width;
  logic y_visible;
  logic hblank_entry;
  logic vblank_entry;

  assign vis_width    = narrow_960 ? H_NAR_X : H_VIS_X;
  assign y_visible    = (y < V_VIS_Y);

  assign blank        = (x >= vis_width) || !y_visible;
  assign hsync        = !((x >= HS_START_X) && (x < HS_END_X));
  assign vsync        = !((y >= VS_START_Y) && (y < VS_END_Y));
  assign retrace      = (x == H_LAST_X) && y_visible;

  assign hblank_entry = (x == vis_width) && y_visible;
  assign vblank_entry = (x == '0) && (y == V_VIS_Y);

  logic irq_set;
  logic irq_q;
  logic irq_d;

  assign irq_set   = (hblank_entry && enable_interrupt_on_hblank) ||
                     (vblank_entry && enable_interrupt_on_vblank);
  assign interrupt = irq_q;

  // A new entry outranks a simultaneous software clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (cli) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_1024x768.sv
// ============================================================================
// tb_vga_timing_1024x768 : random-stimulus bench for the full-size timing block
//                          and a shrunken-raster instance, against a frame model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_1024x768;

  localparam int N_CYCLES = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cli, en_h, en_v, narrow;

  logic [10:0] x_b, x_s;
  logic [9:0]  y_b, y_s;
  logic        hs_b, vs_b, rt_b, bl_b, irq_b;
  logic        hs_s, vs_s, rt_s, bl_s, irq_s;

  vga_timing_1024x768 u_dut_big (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .cli                        (cli),
    .enable_interrupt_on_hblank (en_h),
    .enable_interrupt_on_vblank (en_v),
    .narrow_960                 (narrow),
    .x                          (x_b),
    .y                          (y_b),
    .hsync                      (hs_b),
    .vsync                      (vs_b),
    .retrace                    (rt_b),
    .blank                      (bl_b),
    .interrupt                  (irq_b)
  );

  // Small raster so vertical sync, vertical blank and frame wrap are reached quickly.
  vga_timing_1024x768 #(
    .H_VISIBLE      (32),
    .H_FRONT        (4),
    .H_SYNC         (8),
    .H_BACK         (6),
    .V_VISIBLE      (12),
    .V_FRONT        (2),
    .V_SYNC         (3),
    .V_BACK         (3),
    .NARROW_VISIBLE (24)
  ) u_dut_small (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .cli                        (cli),
    .enable_interrupt_on_hblank (en_h),
    .enable_interrupt_on_vblank (en_v),
    .narrow_960                 (narrow),
    .x                          (x_s),
    .y                          (y_s),
    .hsync                      (hs_s),
    .vsync                      (vs_s),
    .retrace                    (rt_s),
    .blank                      (bl_s),
    .interrupt                  (irq_s)
  );

  int P_HV[2] = '{1024, 32};
  int P_HF[2] = '{24,   4};
  int P_HS[2] = '{136,  8};
  int P_HB[2] = '{160,  6};
  int P_VV[2] = '{768,  12};
  int P_VF[2] = '{3,    2};
  int P_VS[2] = '{6,    3};
  int P_VB[2] = '{29,   3};
  int P_NV[2] = '{960,  24};

  // Model state: position within the frame as a flat cycle index, plus the interrupt.
  int m_n[2];
  int m_irq[2];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input int dut, input logic [31:0] obs,
                          input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      if (tests_failed <= 20)
        $display("FAIL %s dut%0d got=%0d expected=%0d at %0t", tag, dut, obs, exp, $time);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    cli    = 1'b0;
    en_h   = 1'b0;
    en_v   = 1'b0;
    narrow = 1'b0;
    repeat (2) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_n[d]   = 0;
      m_irq[d] = 0;
    end

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);

      for (int d = 0; d < 2; d++) begin
        int ht, ex, ey, w, hs0;
        logic [31:0] ox, oy, ohs, ovs, ort, obl, oirq;
        ht  = P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
        ex  = m_n[d] % ht;
        ey  = m_n[d] / ht;
        w   = narrow ? P_NV[d] : P_HV[d];
        hs0 = P_HV[d] + P_HF[d];
        if (d == 0) begin
          ox = x_b; oy = y_b; ohs = hs_b; ovs = vs_b; ort = rt_b; obl = bl_b; oirq = irq_b;
        end else begin
          ox = x_s; oy = y_s; ohs = hs_s; ovs = vs_s; ort = rt_s; obl = bl_s; oirq = irq_s;
        end
        check_eq("x", d, ox, ex);
        check_eq("y", d, oy, ey);
        check_eq("hsync", d, ohs, (ex >= hs0 && ex < hs0 + P_HS[d]) ? 0 : 1);
        check_eq("vsync", d, ovs,
                 (ey >= P_VV[d] + P_VF[d] && ey < P_VV[d] + P_VF[d] + P_VS[d]) ? 0 : 1);
        check_eq("retrace", d, ort, (ex == ht - 1 && ey < P_VV[d]) ? 1 : 0);
        check_eq("blank", d, obl, (ex >= w || ey >= P_VV[d]) ? 1 : 0);
        check_eq("interrupt", d, oirq, m_irq[d]);
      end

      // Two mid-run resets: one held several cycles, one single-cycle.
      rst_n = !((cyc >= 30000 && cyc < 30003) || cyc == 45000);
      cli   = ($urandom_range(7) == 0);
      en_h  = ($urandom_range(3) == 0);
      en_v  = ($urandom_range(1) == 0);
      if ($urandom_range(499) == 0) narrow = ~narrow;

      for (int d = 0; d < 2; d++) begin
        int ht, vt, ex, ey, w;
        logic hent, vent;
        ht   = P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
        vt   = P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d];
        ex   = m_n[d] % ht;
        ey   = m_n[d] / ht;
        w    = narrow ? P_NV[d] : P_HV[d];
        hent = (ex == w) && (ey < P_VV[d]);
        vent = (ex == 0) && (ey == P_VV[d]);
        if (!rst_n) begin
          m_n[d]   = 0;
          m_irq[d] = 0;
        end else begin
          if ((hent && en_h) || (vent && en_v)) m_irq[d] = 1;
          else if (cli)                         m_irq[d] = 0;
          m_n[d] = (m_n[d] + 1) % (ht * vt);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
